adc_spi_reader: RTL and testbench
=================================

# adc_spi_reader

SPI receiver for the dual 14-bit sampling ADC on the board's shared SPI bus. This block is the input-side counterpart of the DAC driver. It issues a conversion strobe and clocks out one 34-bit frame on SPI_SCK. It deserialises SPI_MISO into two signed channel samples and presents them with a one-cycle done pulse. Signal-processing logic or the waveform generator can use the samples, for example in an ADC→DAC loopback.

## Interface
- SCK_DIV, 4, SPI_SCK period in CLK_50M cycles. Must be even and ≥2. High and low phases are each SCK_DIV/2 cycles.
- CLK_50M  in  1  system clock, 50 MHz. All logic runs on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  frame request. Sampled only in IDLE.
- SPI_MISO  in  1  serial data from the ADC, MSB first.
- SPI_SCK  out  1  SPI clock. Idles low.
- AD_CONV  out  1  conversion strobe to the ADC.
- busy  out  1  high from frame acceptance until done.
- done  out  1  one-cycle pulse. Va and Vb are valid and new.
- Va  out  14  channel A sample, two's complement.
- Vb  out  14  channel B sample, two's complement.

## Operation
- FSM states are IDLE, CONV, SHIFT and DONE.
- IDLE: SPI_SCK=0, AD_CONV=0, busy=0. With start=1 at an edge, go to CONV and set busy=1.
- CONV: AD_CONV=1 for SCK_DIV cycles. SPI_SCK stays 0. Then go to SHIFT and set AD_CONV=0.
- SHIFT: runs 34 SCK periods. Bit index b runs 0..33.
  - Each period has a low phase of SCK_DIV/2 cycles, then a high phase of SCK_DIV/2 cycles.
  - SPI_MISO is registered on the edge that drives SPI_SCK 0→1.
- Frame bit map:
  - b0–1: ignored.
  - b2–15: channel A, MSB first.
  - b16–17: ignored.
  - b18–31: channel B, MSB first.
  - b32–33: ignored.
- After the high phase of b33, go to DONE with SPI_SCK=0.
- DONE lasts one cycle:
  - Load the shift contents into Va and Vb.
  - Pulse done=1 and clear busy.
  - Return to IDLE.
- Va and Vb change only in DONE. Otherwise they hold their last value.
- start outside IDLE is ignored, with no queuing. If start is held high, frames run back-to-back.
- Bit counter width is 6. Phase counter width is ceil(log2(SCK_DIV)). No wrap-around beyond b33.
- Reset (RESET_N=0, any time, including mid-frame) acts immediately:
  - State returns to IDLE.
  - SPI_SCK=0, AD_CONV=0, busy=0, done=0.
  - Va=0, Vb=0, and the shift register clears.
  - A partial frame is discarded. Leaving reset does not start a frame unless start=1.

## Timing
- Start accepted at edge k gives:
  - busy=1 and AD_CONV=1 from k+1.
  - AD_CONV=0 and SHIFT from k+1+SCK_DIV.
  - The first SPI_SCK rise at k+1+SCK_DIV+SCK_DIV/2.
  - done=1 and Va/Vb updated in cycle k+1+35·SCK_DIV. With the default this is k+141.
- DONE/IDLE overlap: busy=0 in the done cycle. The following IDLE cycle samples start, so the earliest next AD_CONV is k+1+35·SCK_DIV+2.
- Held start gives a frame period of 35·SCK_DIV+2 cycles. With the default this is 142.
- SPI_SCK duty is exactly 50%. Frequency is 50/SCK_DIV MHz, 12.5 MHz by default.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The ADC model in the bench updates SPI_MISO on the SPI_SCK falling edge. It must be stable at the rising edge.

## Test plan
- Reset: hold RESET_N=0 for 5 cycles with start=1 → SPI_SCK=0, AD_CONV=0, busy=0, done=0, Va=0, Vb=0. After release, the first AD_CONV rises 2 cycles later.
- Single frame: the ADC model sends channel A=14'h1ABC and channel B=14'h2001, with ignored bits driven 1. Expected results:
  - done pulses exactly once, at start+141.
  - Va=14'h1ABC and Vb=14'h2001 (negative).
  - 34 SPI_SCK rising edges are counted.
  - AD_CONV is high for 4 cycles.
- Ignore-while-busy: pulse start again at start+10 and start+100 → still one frame, one done, and no extra AD_CONV.
- Back-to-back: hold start=1 for 3 frames with values 0x0000/0x3FFF, 0x1FFF/0x2000 and 0x0001/0x3FFE → done pulses 142 cycles apart, and Va/Vb match each frame in order.
- Reset mid-frame: assert RESET_N=0 at SCK edge 20 → outputs zero immediately and no done. The next full frame decodes correctly.
- Parameter: SCK_DIV=2 → SPI_SCK is 25 MHz with 1 cycle high and 1 cycle low. done at start+71, and data decodes correctly.

Source files
------------

// File: rtl/adc_spi_reader.sv
// SPI receiver for the dual 14-bit ADC: strobes AD_CONV, clocks out a 34-bit
// frame on SPI_SCK and presents both signed channel samples with a done pulse.
module adc_spi_reader #(
    parameter int SCK_DIV = 4
) (
    input  logic        CLK_50M,
    input  logic        RESET_N,
    input  logic        start,
    input  logic        SPI_MISO,
    output logic        SPI_SCK,
    output logic        AD_CONV,
    output logic        busy,
    output logic        done,
    output logic [13:0] Va,
    output logic [13:0] Vb
);

    localparam int HALF = SCK_DIV / 2;
    localparam int PW   = $clog2(SCK_DIV);

    localparam logic [PW-1:0] PH_RISE  = PW'(HALF - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(SCK_DIV - 1);
    localparam logic [5:0]    BIT_LAST = 6'd33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] ph_q;
    logic [5:0]    bit_q;
    logic [27:0]   sh_q;
    logic          sck_q;
    logic          conv_q;
    logic          busy_q;
    logic          done_q;
    logic [13:0]   va_q;
    logic [13:0]   vb_q;
    logic          data_bit;

    // Only the 28 sample bits are kept; the six padding bits never enter the register.
    assign data_bit = ((bit_q >= 6'd2)  && (bit_q <= 6'd15)) ||
                      ((bit_q >= 6'd18) && (bit_q <= 6'd31));

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sck_q   <= 1'b0;
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            va_q    <= '0;
            vb_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                        conv_q  <= 1'b1;
                        ph_q    <= '0;
                    end
                end
                CONV: begin
                    if (ph_q == PH_LAST) begin
                        state_q <= SHIFT;
                        conv_q  <= 1'b0;
                        ph_q    <= '0;
                        bit_q   <= '0;
                    end else begin
                        ph_q <= ph_q + PW'(1);
                    end
                end
                SHIFT: begin
                    if (ph_q == PH_RISE) begin
                        sck_q <= 1'b1;
                        if (data_bit) sh_q <= {sh_q[26:0], SPI_MISO};
                    end
                    if (ph_q == PH_LAST) begin
                        sck_q <= 1'b0;
                        ph_q  <= '0;
                        // Results and done are registered on the way into DONE so
                        // they are visible during the DONE cycle itself.
                        if (bit_q == BIT_LAST) begin
                            state_q <= DONE;
                            va_q    <= sh_q[27:14];
                            vb_q    <= sh_q[13:0];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 6'd1;
                        end
                    end else begin
                        ph_q <= ph_q + PW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SPI_SCK = sck_q;
    assign AD_CONV = conv_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign Va      = va_q;
    assign Vb      = vb_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: ADC frame models feed two instances (SCK_DIV 4 and 2)
// and monitors check decode, latency, clocking and reset behaviour.
module tb_adc_spi_reader;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n;
    logic        st1, miso1, sck1, conv1, busy1, done1;
    logic [13:0] va1, vb1;
    logic        st2, miso2, sck2, conv2, busy2, done2;
    logic [13:0] va2, vb2;

    adc_spi_reader #(.SCK_DIV(4)) dut (
        .CLK_50M(clk), .RESET_N(rst_n), .start(st1), .SPI_MISO(miso1),
        .SPI_SCK(sck1), .AD_CONV(conv1), .busy(busy1), .done(done1),
        .Va(va1), .Vb(vb1)
    );

    adc_spi_reader #(.SCK_DIV(2)) dut2 (
        .CLK_50M(clk), .RESET_N(rst_n), .start(st2), .SPI_MISO(miso2),
        .SPI_SCK(sck2), .AD_CONV(conv2), .busy(busy2), .done(done2),
        .Va(va2), .Vb(vb2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Frame as the ADC sends it, bit 0 first: 2 pad, A, 2 pad, B, 2 pad.
    function automatic logic [33:0] frm(input logic [13:0] a, input logic [13:0] b,
                                        input logic [5:0] ig);
        return {ig[5:4], a, ig[3:2], b, ig[1:0]};
    endfunction

    // ADC models: load a frame on AD_CONV rise, advance on SCK fall.
    logic [33:0] fq1[$], fq2[$];
    logic [33:0] fr1, fr2;
    int bi1, bi2;
    initial begin miso1 = 1'b0; miso2 = 1'b0; end

    always @(posedge conv1) begin
        fr1 = (fq1.size() > 0) ? fq1.pop_front() : 34'({$urandom(), $urandom()});
        bi1 = 0;
        miso1 = fr1[33];
    end
    always @(negedge sck1) begin
        bi1++;
        miso1 = (bi1 < 34) ? fr1[33-bi1] : 1'b0;
    end
    always @(posedge conv2) begin
        fr2 = (fq2.size() > 0) ? fq2.pop_front() : 34'({$urandom(), $urandom()});
        bi2 = 0;
        miso2 = fr2[33];
    end
    always @(negedge sck2) begin
        bi2++;
        miso2 = (bi2 < 34) ? fr2[33-bi2] : 1'b0;
    end

    // Monitors sample mid-cycle.
    int cyc = 0;
    int r1, cc1, cr1, r2, cc2, cr2, hi2;
    int dq1[$], dq2[$];
    logic [13:0] aq1[$], bq1[$], aq2[$], bq2[$];
    logic psck1 = 1'b0, pconv1 = 1'b0, psck2 = 1'b0, pconv2 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (sck1 && !psck1) r1++;
        if (conv1) cc1++;
        if (conv1 && !pconv1) cr1++;
        if (done1) begin dq1.push_back(cyc); aq1.push_back(va1); bq1.push_back(vb1); end
        if (sck2 && !psck2) r2++;
        if (sck2) hi2++;
        if (conv2) cc2++;
        if (conv2 && !pconv2) cr2++;
        if (done2) begin dq2.push_back(cyc); aq2.push_back(va2); bq2.push_back(vb2); end
        psck1 = sck1; pconv1 = conv1; psck2 = sck2; pconv2 = conv2;
    end

    task automatic clr();
        r1 = 0; cc1 = 0; cr1 = 0; r2 = 0; cc2 = 0; cr2 = 0; hi2 = 0;
        dq1.delete(); aq1.delete(); bq1.delete();
        dq2.delete(); aq2.delete(); bq2.delete();
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 4) st1 = v;
        else st2 = v;
    endtask

    task automatic frame_test(input int d, input logic [13:0] a, input logic [13:0] b,
                              input logic [5:0] ig, input bit pulses, input string tag);
        int k, n, nd, lat, rises, cnv, crs;
        logic [13:0] ga, gb;
        clr();
        if (d == 4) fq1.push_back(frm(a, b, ig));
        else fq2.push_back(frm(a, b, ig));
        @(negedge clk); set_start(d, 1'b1);
        @(posedge clk); k = cyc;
        @(negedge clk); set_start(d, 1'b0);
        repeat (35*d + 20) begin
            @(negedge clk); #1;
            n = cyc - k;
            set_start(d, pulses && (n == 10 || n == 100));
        end
        if (d == 4) begin
            nd = dq1.size(); lat = (nd > 0) ? dq1[0] - k : -1;
            ga = (nd > 0) ? aq1[0] : 14'h0; gb = (nd > 0) ? bq1[0] : 14'h0;
            rises = r1; cnv = cc1; crs = cr1;
        end else begin
            nd = dq2.size(); lat = (nd > 0) ? dq2[0] - k : -1;
            ga = (nd > 0) ? aq2[0] : 14'h0; gb = (nd > 0) ? bq2[0] : 14'h0;
            rises = r2; cnv = cc2; crs = cr2;
            chk({tag, "_sck_hi_cycles"}, hi2, 34);
        end
        chk({tag, "_dones"}, nd, 1);
        chk({tag, "_lat"}, lat, 35*d + 1);
        chk({tag, "_va"}, ga, a);
        chk({tag, "_vb"}, gb, b);
        chk({tag, "_sck_rises"}, rises, 34);
        chk({tag, "_conv_cycles"}, cnv, d);
        chk({tag, "_conv_rises"}, crs, 1);
    endtask

    initial begin
        int k, nd, t;
        logic [13:0] ea[3], eb[3];

        // Reset held with start asserted.
        rst_n = 1'b0; st1 = 1'b1; st2 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sck", sck1, 0);
        chk("rst_conv", conv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_va", va1, 0);
        chk("rst_vb", vb1, 0);
        @(negedge clk); rst_n = 1'b1; clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rel_conv", conv1, 1);
        chk("rst_rel_busy", busy1, 1);
        @(negedge clk); st1 = 1'b0;
        repeat (160) @(negedge clk);
        chk("rst_rel_dones", dq1.size(), 1);

        // Single frame with pad bits driven high.
        frame_test(4, 14'h1ABC, 14'h2001, 6'h3F, 1'b0, "single");
        // Start pulses while busy must be ignored.
        frame_test(4, 14'($urandom()), 14'($urandom()), 6'($urandom()), 1'b1, "ign_busy");
        for (int i = 0; i < 2; i++)
            frame_test(4, 14'($urandom()), 14'($urandom()), 6'($urandom()), 1'b0, "rand");

        // Back-to-back with start held.
        ea[0] = 14'h0000; eb[0] = 14'h3FFF;
        ea[1] = 14'h1FFF; eb[1] = 14'h2000;
        ea[2] = 14'h0001; eb[2] = 14'h3FFE;
        clr();
        for (int i = 0; i < 3; i++) fq1.push_back(frm(ea[i], eb[i], 6'($urandom())));
        @(negedge clk); st1 = 1'b1;
        @(posedge clk); k = cyc;
        t = 0;
        while (dq1.size() < 3 && t < 600) begin
            @(negedge clk); #1; t++;
        end
        st1 = 1'b0;
        repeat (20) @(negedge clk);
        nd = dq1.size();
        chk("b2b_dones", nd, 3);
        chk("b2b_lat0", (nd > 0) ? dq1[0] - k : -1, 141);
        for (int i = 1; i < 3; i++)
            chk($sformatf("b2b_period%0d", i), (nd > i) ? dq1[i] - dq1[i-1] : -1, 142);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_va%0d", i), (nd > i) ? aq1[i] : 14'h0, ea[i]);
            chk($sformatf("b2b_vb%0d", i), (nd > i) ? bq1[i] : 14'h0, eb[i]);
        end
        chk("b2b_conv_rises", cr1, 3);

        // Reset in the middle of a frame.
        clr();
        @(negedge clk); st1 = 1'b1;
        @(negedge clk); st1 = 1'b0;
        t = 0;
        while (r1 < 20 && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk("mid_reached_sck20", r1, 20);
        rst_n = 1'b0;
        #1;
        chk("mid_sck", sck1, 0);
        chk("mid_busy", busy1, 0);
        chk("mid_conv", conv1, 0);
        chk("mid_done", done1, 0);
        chk("mid_va", va1, 0);
        chk("mid_vb", vb1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; clr();
        repeat (200) @(negedge clk);
        chk("mid_no_done", dq1.size(), 0);
        chk("mid_no_conv", cr1, 0);
        frame_test(4, 14'($urandom()), 14'($urandom()), 6'($urandom()), 1'b0, "after_mid");

        // Fastest clock divider.
        frame_test(2, 14'h1ABC, 14'h2001, 6'h3F, 1'b0, "div2");
        frame_test(2, 14'($urandom()), 14'($urandom()), 6'($urandom()), 1'b0, "div2_rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
